// File: rtl/reg_file_scoreboard.sv
// Integer register file with same-cycle WB bypass and a per-register pending-writer
// scoreboard that stalls ID on read-after-write hazards and counter saturation.
module reg_file_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rd_WBID,
  input  logic             reg_wr_en_WBID,
  input  logic [WIDTH-1:0] reg_wr_data_WBID,
  input  logic             sb_release_WBID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic             issue_en_ID,
  input  logic             issue_wr_ID,
  input  logic [4:0]       issue_rd_ID,
  output logic [WIDTH-1:0] rs1_data_ID,
  output logic [WIDTH-1:0] rs2_data_ID,
  output logic             stall_ID
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] regs [NREGS];
  logic [CNT_W-1:0] cnt  [NREGS];

  logic             haz1, haz2, sat, acc;
  logic [CNT_W-1:0] eff1, eff2, eff_rd;

  // Count remaining after this cycle's WB retire; a release against zero is ignored.
  function automatic logic [CNT_W-1:0] eff_cnt(input logic [CNT_W-1:0] c,
                                                input logic             rel);
    return (rel && c != '0) ? c - 1'b1 : c;
  endfunction

  function automatic logic rel_hit(input logic [4:0] r, input logic       rel_en,
                                   input logic [4:0] wb_rd);
    return rel_en && (wb_rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [WIDTH-1:0] read_port(input logic [4:0]       rs,
                                                 input logic [WIDTH-1:0] arr_val,
                                                 input logic             wr_en,
                                                 input logic [4:0]       wb_rd,
                                                 input logic [WIDTH-1:0] wb_data);
    if (rs == 5'd0)
      return '0;
    else if (wr_en && wb_rd == rs)
      return wb_data;
    else
      return arr_val;
  endfunction

  always_comb begin
    eff1   = eff_cnt(cnt[rs1_ID], rel_hit(rs1_ID, sb_release_WBID, rd_WBID));
    eff2   = eff_cnt(cnt[rs2_ID], rel_hit(rs2_ID, sb_release_WBID, rd_WBID));
    eff_rd = eff_cnt(cnt[issue_rd_ID], rel_hit(issue_rd_ID, sb_release_WBID, rd_WBID));

    haz1 = rs1_used_ID && (rs1_ID != 5'd0) && (eff1 != '0);
    haz2 = rs2_used_ID && (rs2_ID != 5'd0) && (eff2 != '0);
    sat  = issue_en_ID && issue_wr_ID && (issue_rd_ID != 5'd0) && (eff_rd == CNT_MAX);

    // Outputs are forced quiet while reset is held so nothing leaks through the bypass.
    stall_ID = reset_n && issue_en_ID && (haz1 || haz2 || sat);
    acc      = issue_en_ID && !stall_ID && issue_wr_ID && (issue_rd_ID != 5'd0);

    rs1_data_ID = reset_n ? read_port(rs1_ID, regs[rs1_ID], reg_wr_en_WBID, rd_WBID,
                                      reg_wr_data_WBID) : '0;
    rs2_data_ID = reset_n ? read_port(rs2_ID, regs[rs2_ID], reg_wr_en_WBID, rd_WBID,
                                      reg_wr_data_WBID) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      regs[0] <= '0;
      cnt[0]  <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (reg_wr_en_WBID && rd_WBID == 5'(i))
          regs[i] <= reg_wr_data_WBID;
        // Issue and release on the same register cancel; acc already excludes saturation.
        if ((acc && issue_rd_ID == 5'(i)) && !rel_hit(5'(i), sb_release_WBID, rd_WBID))
          cnt[i] <= cnt[i] + 1'b1;
        else if (!(acc && issue_rd_ID == 5'(i)) && rel_hit(5'(i), sb_release_WBID, rd_WBID)
                 && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Releasing a register with no writer in flight means the pipeline lost track.
  assert property (@(posedge clk) disable iff (!reset_n)
                   (sb_release_WBID && rd_WBID != 5'd0) |-> (cnt[rd_WBID] != '0));

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: reset, write/bypass, x0, RAW stall,
// counter saturation, squash release and asynchronous reset during a stall.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rd_WBID;
  logic        reg_wr_en_WBID;
  logic [31:0] reg_wr_data_WBID;
  logic        sb_release_WBID;
  logic [4:0]  rs1_ID, rs2_ID;
  logic        rs1_used_ID, rs2_used_ID;
  logic        issue_en_ID, issue_wr_ID;
  logic [4:0]  issue_rd_ID;
  logic [31:0] rs1_data_ID, rs2_data_ID;
  logic        stall_ID;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard #(.WIDTH(32), .NREGS(32), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_WBID(rd_WBID), .reg_wr_en_WBID(reg_wr_en_WBID),
    .reg_wr_data_WBID(reg_wr_data_WBID), .sb_release_WBID(sb_release_WBID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .issue_en_ID(issue_en_ID), .issue_wr_ID(issue_wr_ID), .issue_rd_ID(issue_rd_ID),
    .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID), .stall_ID(stall_ID)
  );

  typedef struct {
    logic [4:0]  rd;   logic we; logic [31:0] wd; logic rel;
    logic [4:0]  rs1;  logic [4:0] rs2; logic u1; logic u2;
    logic        ie;   logic iw; logic [4:0] ird;
    logic [31:0] e1;   logic [31:0] e2; logic est;
  } vec_t;

  function automatic vec_t mk(logic [4:0] rd, logic we, logic [31:0] wd, logic rel,
                              logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic ie, logic iw, logic [4:0] ird,
                              logic [31:0] e1, logic [31:0] e2, logic est);
    vec_t v;
    v.rd = rd; v.we = we; v.wd = wd; v.rel = rel;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.ie = ie; v.iw = iw; v.ird = ird;
    v.e1 = e1; v.e2 = e2; v.est = est;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rd_WBID = v.rd; reg_wr_en_WBID = v.we; reg_wr_data_WBID = v.wd; sb_release_WBID = v.rel;
    rs1_ID = v.rs1; rs2_ID = v.rs2; rs1_used_ID = v.u1; rs2_used_ID = v.u2;
    issue_en_ID = v.ie; issue_wr_ID = v.iw; issue_rd_ID = v.ird;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  vec_t vecs [27];

  initial begin
    //            rd we wd            rel rs1 rs2 u1 u2 ie iw ird  e1            e2        st
    vecs[0]  = mk(0, 0, 0,            0,  1,  2,  1, 1, 1, 0, 0,   0,            0,        0);
    vecs[1]  = mk(5, 1, 32'hDEADBEEF, 0,  5,  0,  1, 1, 1, 0, 0,   32'hDEADBEEF, 0,        0);
    vecs[2]  = mk(0, 0, 0,            0,  5,  0,  1, 0, 1, 0, 0,   32'hDEADBEEF, 0,        0);
    vecs[3]  = mk(0, 1, 32'h1234,     0,  0,  0,  1, 1, 1, 0, 0,   0,            0,        0);
    vecs[4]  = mk(0, 0, 0,            0,  5,  0,  1, 1, 1, 0, 0,   32'hDEADBEEF, 0,        0);
    vecs[5]  = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 7,   0,            0,        0);
    vecs[6]  = mk(0, 0, 0,            0,  7,  0,  1, 0, 1, 0, 0,   0,            0,        1);
    vecs[7]  = mk(0, 0, 0,            0,  7,  0,  1, 0, 1, 0, 0,   0,            0,        1);
    vecs[8]  = mk(7, 1, 32'h77,       1,  7,  0,  1, 0, 1, 0, 0,   32'h77,       0,        0);
    vecs[9]  = mk(0, 0, 0,            0,  7,  0,  1, 0, 1, 0, 0,   32'h77,       0,        0);
    vecs[10] = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 3,   0,            0,        0);
    vecs[11] = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 3,   0,            0,        0);
    vecs[12] = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 3,   0,            0,        0);
    vecs[13] = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 3,   0,            0,        1);
    vecs[14] = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 3,   0,            0,        1);
    vecs[15] = mk(3, 1, 32'h33,       1,  0,  0,  0, 0, 1, 1, 3,   0,            0,        0);
    vecs[16] = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 3,   0,            0,        1);
    vecs[17] = mk(3, 1, 32'h34,       1,  0,  3,  0, 1, 0, 0, 0,   0,            32'h34,   0);
    vecs[18] = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 3,   0,            0,        0);
    vecs[19] = mk(3, 0, 0,            1,  3,  0,  0, 0, 0, 0, 0,   32'h34,       0,        0);
    vecs[20] = mk(3, 0, 0,            1,  3,  0,  0, 0, 0, 0, 0,   32'h34,       0,        0);
    vecs[21] = mk(3, 0, 0,            1,  3,  0,  0, 0, 0, 0, 0,   32'h34,       0,        0);
    vecs[22] = mk(0, 0, 0,            0,  3,  0,  1, 0, 1, 0, 0,   32'h34,       0,        0);
    vecs[23] = mk(0, 0, 0,            0,  0,  0,  0, 0, 1, 1, 9,   0,            0,        0);
    vecs[24] = mk(0, 0, 0,            0,  0,  9,  0, 1, 1, 0, 0,   0,            0,        1);
    vecs[25] = mk(9, 0, 32'hBAD,      1,  0,  9,  0, 1, 1, 0, 0,   0,            0,        0);
    vecs[26] = mk(0, 0, 0,            0,  0,  9,  0, 1, 1, 0, 0,   0,            0,        0);

    // Reset held: bypass write and issue attempts must not show on the outputs.
    reset_n = 1'b0;
    apply(mk(5, 1, 32'hDEADBEEF, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0));
    for (int i = 1; i < 32; i++) begin
      rs1_ID = 5'(i); rs2_ID = 5'(32 - i);
      #1;
      check($sformatf("rst_rs1_x%0d", i), rs1_data_ID, 0);
      check($sformatf("rst_rs2_x%0d", 32 - i), rs2_data_ID, 0);
    end
    check("rst_stall", {31'b0, stall_ID}, 0);

    idle();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rs1_ID = 5'(i); rs2_ID = 5'(i);
      #1;
      check($sformatf("post_rst_x%0d", i), rs1_data_ID, 0);
    end

    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_rs1", i), rs1_data_ID, vecs[i].e1);
      check($sformatf("v%0d_rs2", i), rs2_data_ID, vecs[i].e2);
      check($sformatf("v%0d_stall", i), {31'b0, stall_ID}, {31'b0, vecs[i].est});
    end

    // Asynchronous reset while a consumer is stalled on x9.
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 9, 5, 1, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("midrst_pre_stall", {31'b0, stall_ID}, 1);
    check("midrst_pre_x5", rs2_data_ID, 32'hDEADBEEF);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall_ID}, 0);
    check("midrst_rs2", rs2_data_ID, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("postrst_stall", {31'b0, stall_ID}, 0);
    check("postrst_x5", rs2_data_ID, 0);
    check("postrst_x9", rs1_data_ID, 0);

    idle();
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
